// File: rtl/alu_shifter_datapath.sv
// rtl/alu_shifter_datapath.sv - ARM7TDMI barrel shifter, operand-B select, 32-bit ALU and NZCV flags
module alu_shifter_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] op_a,
  input  logic [31:0] R_in,
  input  logic [3:0]  alu_op,
  input  logic [3:0]  flags_in,
  input  logic        carry_in,
  input  logic [1:0]  shift_type,
  input  logic [4:0]  shift_amount,
  input  logic        shift_latch_amt,
  input  logic        shift_use_latch,
  input  logic        shift_use_rxx,
  input  logic        latch_op_b,
  input  logic        use_op_b_latch,
  input  logic        disable_op_b,
  output logic [31:0] result,
  output logic [3:0]  flags_out,
  output logic [31:0] shifter_out,
  output logic        shifter_carry
);

  localparam logic [1:0] SH_LSL = 2'd0;
  localparam logic [1:0] SH_LSR = 2'd1;
  localparam logic [1:0] SH_ASR = 2'd2;
  localparam logic [1:0] SH_ROR = 2'd3;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  logic [7:0]  amt_latch;
  logic [31:0] opb_latch;
  logic        opb_carry_latch;

  logic [31:0] op_b;
  logic        sc;

  // Each helper returns {carry, value}; amounts up to 32 fall out of the
  // 33-bit shift naturally (the extra bit catches the last bit shifted out).
  function automatic logic [32:0] f_lsl(input logic [31:0] r, input logic [5:0] n);
    f_lsl = {1'b0, r} << n;
  endfunction

  function automatic logic [32:0] f_lsr(input logic [31:0] r, input logic [5:0] n);
    logic [32:0] t;
    t = {r, 1'b0} >> n;
    f_lsr = {t[0], t[32:1]};
  endfunction

  function automatic logic [32:0] f_asr(input logic [31:0] r, input logic [5:0] n);
    logic signed [32:0] t;
    t = $signed({r, 1'b0}) >>> n;
    f_asr = {t[0], t[32:1]};
  endfunction

  // Rotate by m; the carry is the bit that lands in position 31, which also
  // gives R_in[31] for a zero rotate (register ROR by a nonzero multiple of 32).
  function automatic logic [32:0] f_ror(input logic [31:0] r, input logic [4:0] m);
    logic [63:0] t;
    t = {r, r} >> m;
    f_ror = {t[31], t[31:0]};
  endfunction

  // Barrel shifter: register-specified rules when using the latched amount,
  // immediate rules (with optional #0 special encodings) otherwise.
  always_comb begin
    logic [32:0] cv;
    cv = {carry_in, R_in};
    if (shift_use_latch) begin
      if (amt_latch != 8'd0) begin
        case (shift_type)
          SH_LSL: cv = (amt_latch <= 8'd32) ? f_lsl(R_in, amt_latch[5:0]) : 33'd0;
          SH_LSR: cv = (amt_latch <= 8'd32) ? f_lsr(R_in, amt_latch[5:0]) : 33'd0;
          SH_ASR: cv = (amt_latch <= 8'd32) ? f_asr(R_in, amt_latch[5:0]) : f_asr(R_in, 6'd32);
          default: cv = f_ror(R_in, amt_latch[4:0]);
        endcase
      end
    end else if (shift_amount != 5'd0) begin
      case (shift_type)
        SH_LSL: cv = f_lsl(R_in, {1'b0, shift_amount});
        SH_LSR: cv = f_lsr(R_in, {1'b0, shift_amount});
        SH_ASR: cv = f_asr(R_in, {1'b0, shift_amount});
        default: cv = f_ror(R_in, shift_amount);
      endcase
    end else if (shift_use_rxx) begin
      case (shift_type)
        SH_LSR: cv = f_lsr(R_in, 6'd32);
        SH_ASR: cv = f_asr(R_in, 6'd32);
        SH_ROR: cv = {R_in[0], carry_in, R_in[31:1]};
        default: cv = {carry_in, R_in};
      endcase
    end
    shifter_carry = cv[32];
    shifter_out   = cv[31:0];
  end

  // Operand B select: disable beats the latch, the latch beats the live shifter.
  always_comb begin
    op_b = shifter_out;
    sc   = shifter_carry;
    if (disable_op_b) begin
      op_b = 32'd0;
      sc   = carry_in;
    end else if (use_op_b_latch) begin
      op_b = opb_latch;
      sc   = opb_carry_latch;
    end
  end

  // ALU: arithmetic ops reduce to x + y + cin; logical ops pass the shifter carry.
  always_comb begin
    logic [31:0] x;
    logic [31:0] y;
    logic        cin;
    logic [32:0] sum;
    logic        arith;
    logic        c_flag;
    logic        v_flag;
    x     = op_a;
    y     = op_b;
    cin   = 1'b0;
    arith = 1'b1;
    case (alu_op)
      OP_ADD, OP_CMN: cin = 1'b0;
      OP_ADC:         cin = flags_in[1];
      OP_SUB, OP_CMP: begin y = ~op_b; cin = 1'b1; end
      OP_SBC:         begin y = ~op_b; cin = flags_in[1]; end
      OP_RSB:         begin x = op_b; y = ~op_a; cin = 1'b1; end
      OP_RSC:         begin x = op_b; y = ~op_a; cin = flags_in[1]; end
      default:        arith = 1'b0;
    endcase
    sum = {1'b0, x} + {1'b0, y} + {32'd0, cin};
    case (alu_op)
      OP_AND, OP_TST: result = op_a & op_b;
      OP_EOR, OP_TEQ: result = op_a ^ op_b;
      OP_ORR:         result = op_a | op_b;
      OP_MOV:         result = op_b;
      OP_BIC:         result = op_a & ~op_b;
      OP_MVN:         result = ~op_b;
      default:        result = sum[31:0];
    endcase
    if (arith) begin
      c_flag = sum[32];
      v_flag = (x[31] == y[31]) && (sum[31] != x[31]);
    end else begin
      c_flag = sc;
      v_flag = flags_in[0];
    end
    flags_out = {result[31], (result == 32'd0), c_flag, v_flag};
  end

  // Shift-amount latch and operand-B latch; cleared asynchronously on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      amt_latch       <= 8'd0;
      opb_latch       <= 32'd0;
      opb_carry_latch <= 1'b0;
    end else begin
      if (shift_latch_amt) amt_latch <= R_in[7:0];
      if (latch_op_b) begin
        opb_latch       <= shifter_out;
        opb_carry_latch <= shifter_carry;
      end
    end
  end

endmodule

// File: tb/tb_alu_shifter_datapath.sv
// tb/tb_alu_shifter_datapath.sv - scoreboard bench for alu_shifter_datapath
module tb_alu_shifter_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] op_a, R_in;
  logic [3:0]  alu_op, flags_in;
  logic        carry_in;
  logic [1:0]  shift_type;
  logic [4:0]  shift_amount;
  logic        shift_latch_amt, shift_use_latch, shift_use_rxx;
  logic        latch_op_b, use_op_b_latch, disable_op_b;
  logic [31:0] result, shifter_out;
  logic [3:0]  flags_out;
  logic        shifter_carry;

  int total = 0;
  int bad = 0;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [3:0]  flg;
    logic [31:0] sh;
    logic        shc;
  } exp_t;

  exp_t sb[$];

  alu_shifter_datapath dut (
    .clk(clk), .reset(reset), .op_a(op_a), .R_in(R_in), .alu_op(alu_op),
    .flags_in(flags_in), .carry_in(carry_in), .shift_type(shift_type),
    .shift_amount(shift_amount), .shift_latch_amt(shift_latch_amt),
    .shift_use_latch(shift_use_latch), .shift_use_rxx(shift_use_rxx),
    .latch_op_b(latch_op_b), .use_op_b_latch(use_op_b_latch),
    .disable_op_b(disable_op_b), .result(result), .flags_out(flags_out),
    .shifter_out(shifter_out), .shifter_carry(shifter_carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Next negedge, all controls back to idle (reset left alone).
  task automatic step();
    @(negedge clk);
    op_a = 0; R_in = 0; alu_op = 4'hD; flags_in = 0; carry_in = 0;
    shift_type = 0; shift_amount = 0; shift_latch_amt = 0; shift_use_latch = 0;
    shift_use_rxx = 0; latch_op_b = 0; use_op_b_latch = 0; disable_op_b = 0;
  endtask

  task automatic vec(input string tag, input logic [31:0] res, input logic [3:0] flg,
                     input logic [31:0] sh, input logic shc);
    exp_t e;
    e.tag = tag; e.res = res; e.flg = flg; e.sh = sh; e.shc = shc;
    sb.push_back(e);
    #2;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.tag, ".res"}, result, e.res);
      check({e.tag, ".flg"}, {28'd0, flags_out}, {28'd0, e.flg});
      check({e.tag, ".sh"}, shifter_out, e.sh);
      check({e.tag, ".shc"}, {31'd0, shifter_carry}, {31'd0, e.shc});
    end
  endtask

  initial begin
    logic [31:0] a, b, r;
    logic [32:0] s;
    logic        v;
    longint      sl;
    reset = 1'b1;
    step();
    step();
    // reset state: latches zero, latched carry zero, latched amount zero
    use_op_b_latch = 1; shift_use_latch = 1; R_in = 32'hABCD; carry_in = 1;
    vec("rst", 32'h0, 4'b0100, 32'hABCD, 1'b1);
    step(); reset = 1'b0;

    step(); alu_op = 4'h4; op_a = 32'h7FFFFFFF; R_in = 1;
    vec("add_ovf", 32'h80000000, 4'b1001, 32'h1, 1'b0);
    step(); alu_op = 4'h2; op_a = 5; R_in = 5;
    vec("sub_eq", 32'h0, 4'b0110, 32'h5, 1'b0);
    step(); alu_op = 4'h2; op_a = 3; R_in = 5;
    vec("sub_neg", 32'hFFFFFFFE, 4'b1000, 32'h5, 1'b0);
    step(); alu_op = 4'h3; op_a = 1; R_in = 0;
    vec("rsb", 32'hFFFFFFFF, 4'b1000, 32'h0, 1'b0);
    step(); alu_op = 4'hB; op_a = 32'hFFFFFFFF; R_in = 1;
    vec("cmn", 32'h0, 4'b0110, 32'h1, 1'b0);
    step(); alu_op = 4'h6; op_a = 0; R_in = 0;
    vec("sbc", 32'hFFFFFFFF, 4'b1000, 32'h0, 1'b0);
    step(); alu_op = 4'h9; op_a = 32'hF0F0; R_in = 32'hF0F0; carry_in = 1; flags_in = 4'b0001;
    vec("teq", 32'h0, 4'b0111, 32'hF0F0, 1'b1);
    step(); alu_op = 4'hE; op_a = 32'hFF; R_in = 32'h0F;
    vec("bic", 32'hF0, 4'b0000, 32'h0F, 1'b0);
    step(); alu_op = 4'hF; R_in = 0;
    vec("mvn", 32'hFFFFFFFF, 4'b1000, 32'h0, 1'b0);
    step(); shift_use_rxx = 1; shift_type = 3; carry_in = 1; R_in = 3;
    vec("rrx", 32'h80000001, 4'b1010, 32'h80000001, 1'b1);
    step(); shift_use_rxx = 1; shift_type = 1; R_in = 32'h80000000;
    vec("lsr0", 32'h0, 4'b0110, 32'h0, 1'b1);
    step(); shift_type = 2; shift_amount = 0; carry_in = 1; R_in = 32'h80000000;
    vec("asr0_norxx", 32'h80000000, 4'b1010, 32'h80000000, 1'b1);

    // register-specified shifts
    step(); shift_latch_amt = 1; R_in = 32'h20;
    vec("lat20", 32'h20, 4'b0000, 32'h20, 1'b0);
    step(); shift_use_latch = 1; shift_type = 1; R_in = 32'h80000000;
    vec("lsr32", 32'h0, 4'b0110, 32'h0, 1'b1);
    step(); shift_use_latch = 1; shift_type = 0; R_in = 1;
    vec("lsl32", 32'h0, 4'b0110, 32'h0, 1'b1);
    step(); shift_latch_amt = 1; shift_use_latch = 1; shift_type = 1; R_in = 32'h21;
    vec("lat21_old", 32'h0, 4'b0100, 32'h0, 1'b0);
    step(); shift_use_latch = 1; shift_type = 0; R_in = 32'hFFFFFFFF;
    vec("lsl33", 32'h0, 4'b0100, 32'h0, 1'b0);
    step(); shift_use_latch = 1; shift_type = 2; R_in = 32'h80000000;
    vec("asr33", 32'hFFFFFFFF, 4'b1010, 32'hFFFFFFFF, 1'b1);
    step(); shift_latch_amt = 1; R_in = 32'h40;
    vec("lat40", 32'h40, 4'b0000, 32'h40, 1'b0);
    step(); shift_use_latch = 1; shift_type = 3; R_in = 32'h80000001;
    vec("ror64", 32'h80000001, 4'b1010, 32'h80000001, 1'b1);
    step(); shift_latch_amt = 1; R_in = 32'h0;
    vec("lat0", 32'h0, 4'b0100, 32'h0, 1'b0);
    step(); shift_use_latch = 1; shift_type = 1; R_in = 32'h1234; carry_in = 1;
    vec("amt0", 32'h1234, 4'b0010, 32'h1234, 1'b1);

    // operand-B latch
    step(); latch_op_b = 1; shift_type = 2; shift_amount = 4; R_in = 32'hF0000000;
    vec("asr4", 32'hFF000000, 4'b1000, 32'hFF000000, 1'b0);
    step(); use_op_b_latch = 1; R_in = 32'h12345678; alu_op = 4'hC; op_a = 32'hFF; flags_in = 1;
    vec("orr_lat", 32'hFF0000FF, 4'b1001, 32'h12345678, 1'b0);
    step(); latch_op_b = 1; use_op_b_latch = 1; shift_type = 1; shift_amount = 1; R_in = 3;
    alu_op = 4'hC; op_a = 32'hFF; flags_in = 1;
    vec("orr_old", 32'hFF0000FF, 4'b1001, 32'h1, 1'b1);
    step(); use_op_b_latch = 1; flags_in = 1;
    vec("lat_new", 32'h1, 4'b0011, 32'h0, 1'b0);
    step(); reset = 1'b1; use_op_b_latch = 1; flags_in = 1;
    vec("lat_rst", 32'h0, 4'b0101, 32'h0, 1'b0);
    step(); reset = 1'b0; use_op_b_latch = 1; flags_in = 1;
    vec("lat_after", 32'h0, 4'b0101, 32'h0, 1'b0);

    // operand-B disable
    step(); disable_op_b = 1; alu_op = 4'h4; op_a = 32'h1234; R_in = 32'hDEAD;
    vec("dis_add", 32'h1234, 4'b0000, 32'hDEAD, 1'b0);
    step(); disable_op_b = 1; alu_op = 4'h5; op_a = 32'h1234; R_in = 32'hDEAD; flags_in = 4'b0010;
    vec("dis_adc", 32'h1235, 4'b0000, 32'hDEAD, 1'b0);
    step(); disable_op_b = 1; use_op_b_latch = 1; carry_in = 1; R_in = 32'h55;
    vec("dis_prio", 32'h0, 4'b0110, 32'h55, 1'b1);

    // random ADD / SUB against an integer model
    for (int i = 0; i < 16; i++) begin
      a = $urandom; b = $urandom;
      if (i == 0) begin a = 32'h80000000; b = 32'h80000000; end
      step(); op_a = a; R_in = b;
      if (i[0]) begin
        alu_op = 4'h2;
        r = a - b;
        sl = longint'($signed(a)) - longint'($signed(b));
        v = (sl > 64'sd2147483647) || (sl < -64'sd2147483648);
        vec("rnd_sub", r, {r[31], r == 0, a >= b, v}, b, 1'b0);
      end else begin
        alu_op = 4'h4;
        s = {1'b0, a} + {1'b0, b};
        sl = longint'($signed(a)) + longint'($signed(b));
        v = (sl > 64'sd2147483647) || (sl < -64'sd2147483648);
        vec("rnd_add", s[31:0], {s[31], s[31:0] == 0, s[32], v}, b, 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
